ap_ctrl_sequencer: RTL and testbench

//  Drives the ap_ctrl_hs block-level handshake of the DelayAndSum kernel for a programmed number of invocations.

---
 rtl/ap_ctrl_pkg.sv | 16 +
 rtl/ts_fifo.sv | 76 +++++++
 rtl/ap_ctrl_sequencer.sv | 177 +++++++++++++++++
 tb/tb_ap_ctrl_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ap_ctrl_pkg.sv
// Shared types for the ap_ctrl_hs sequencer: FSM state encoding and latency type.
package ap_ctrl_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_LAT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        ERR   = 2'd3
    } seq_state_e;

    typedef logic [DEF_LAT_W-1:0] lat_t;

endpackage

// File: rtl/ts_fifo.sv
// Timestamp FIFO: holds the issue stamp of every outstanding transaction.
// Each slot also tracks whether the free-running stamp has lapped it, so the
// reader can tell an age of 2**W or more apart from a small modular difference.
module ts_fifo #(
    parameter int W    = 32,
    parameter int LOG2 = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic           push,
    input  logic           pop,
    input  logic [W-1:0]   wdata,
    input  logic [W-1:0]   stamp_next,
    output logic [W-1:0]   rdata,
    output logic           rwrapped,
    output logic [LOG2:0]  count,
    output logic           full,
    output logic           empty
);

    localparam int DEPTH = 1 << LOG2;
    // Pointers are at least one bit wide; storage is sized to match them so
    // indexing stays width-clean even when only one slot is logically used.
    localparam int PW    = (LOG2 > 0) ? LOG2 : 1;
    localparam int SLOTS = 1 << PW;
    localparam int CW    = LOG2 + 1;

    logic [W-1:0]     mem [SLOTS];
    logic [SLOTS-1:0] valid;
    logic [SLOTS-1:0] wrapped;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && (!full || pop);
    assign pop_ok   = pop && !empty;
    assign rdata    = mem[rd_ptr];
    assign rwrapped = wrapped[rd_ptr];

    // Pointer/occupancy bookkeeping plus per-slot lap detection.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid   <= '0;
            wrapped <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (valid[i] && (mem[i] == stamp_next)) begin
                    wrapped[i] <= 1'b1;
                end
            end
            if (pop_ok) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= bump(rd_ptr);
            end
            if (push_ok) begin
                mem[wr_ptr]     <= wdata;
                valid[wr_ptr]   <= 1'b1;
                wrapped[wr_ptr] <= 1'b0;
                wr_ptr          <= bump(wr_ptr);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// Drives the ap_ctrl_hs handshake of a kernel for a programmed batch of
// invocations, counting issues/completions and measuring issue-to-done latency.
//
// Handshakes: a start is taken when ap_start && ap_ready are both high at a
// rising edge; a completion is taken when ap_done && ap_continue are both high
// at a rising edge and at least one transaction was outstanding before it.
module ap_ctrl_sequencer
    import ap_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int LAT_W    = 32,
    parameter int TIMEOUT  = 1000000,
    parameter int OUT_LOG2 = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_num_txn,
    output logic             busy,
    output logic             finish,
    output logic             timeout_err,
    output logic             proto_err,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic [CNT_W-1:0] txn_issued,
    output logic [CNT_W-1:0] txn_done,
    output logic [LAT_W-1:0] lat_last,
    output logic [LAT_W-1:0] lat_min,
    output logic [LAT_W-1:0] lat_max,
    output seq_state_e       dbg_state
);

    localparam int DEPTH = 1 << OUT_LOG2;
    localparam int OW    = OUT_LOG2 + 1;
    localparam int WD_W  = 32;

    seq_state_e       state;
    logic [CNT_W-1:0] num_q;
    logic [LAT_W-1:0] stamp;
    logic [LAT_W-1:0] head_stamp;
    logic [LAT_W-1:0] lat_now;
    logic             head_wrapped;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OUT_LOG2:0] occ;
    logic [OUT_LOG2:0] occ_nx;
    logic [WD_W-1:0]  wd;
    logic             hs;
    logic             cmp;
    logic             wd_trip;
    logic [CNT_W-1:0] issued_nx;
    logic [CNT_W-1:0] done_nx;

    assign busy        = (state == ISSUE) || (state == DRAIN);
    assign ap_continue = busy;
    assign dbg_state   = state;

    assign hs        = ap_start && ap_ready && !fifo_full;
    assign cmp       = ap_done && ap_continue && !fifo_empty;
    assign issued_nx = txn_issued + CNT_W'(hs);
    assign done_nx   = txn_done + CNT_W'(cmp);
    assign occ_nx    = occ + OW'(hs) - OW'(cmp);
    assign lat_now   = head_wrapped ? '1 : (stamp - head_stamp);
    assign wd_trip   = (TIMEOUT != 0) && !(ap_ready || ap_done) &&
                       (wd == WD_W'(TIMEOUT - 1));

    ts_fifo #(
        .W    (LAT_W),
        .LOG2 (OUT_LOG2)
    ) u_ts_fifo (
        .clock      (clock),
        .reset      (reset),
        .clear      (!busy),
        .push       (hs),
        .pop        (cmp),
        .wdata      (stamp),
        .stamp_next (stamp + LAT_W'(1)),
        .rdata      (head_stamp),
        .rwrapped   (head_wrapped),
        .count      (occ),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Free-running cycle stamp used to timestamp handshakes and completions.
    always_ff @(posedge clock) begin
        if (reset) begin
            stamp <= '0;
        end else begin
            stamp <= stamp + LAT_W'(1);
        end
    end

    // Batch FSM with registered handshake outputs, counters, latency and errors.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            num_q       <= '0;
            txn_issued  <= '0;
            txn_done    <= '0;
            ap_start    <= 1'b0;
            finish      <= 1'b0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
            lat_last    <= '0;
            lat_min     <= '1;
            lat_max     <= '0;
            wd          <= '0;
        end else begin
            finish <= 1'b0;
            if (busy) begin
                txn_issued <= issued_nx;
                txn_done   <= done_nx;
                wd         <= (ap_ready || ap_done) ? '0 : wd + WD_W'(1);
            end
            if (cmp) begin
                lat_last <= lat_now;
                if (lat_now < lat_min) lat_min <= lat_now;
                if (lat_now > lat_max) lat_max <= lat_now;
            end
            unique case (state)
                IDLE, ERR: begin
                    if (cfg_start) begin
                        if (cfg_num_txn != '0) begin
                            num_q       <= cfg_num_txn;
                            txn_issued  <= '0;
                            txn_done    <= '0;
                            lat_last    <= '0;
                            lat_min     <= '1;
                            lat_max     <= '0;
                            timeout_err <= 1'b0;
                            proto_err   <= 1'b0;
                            wd          <= '0;
                            ap_start    <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            finish <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                ISSUE: begin
                    if (wd_trip) begin
                        state       <= ERR;
                        ap_start    <= 1'b0;
                        timeout_err <= 1'b1;
                        finish      <= 1'b1;
                    end else if (issued_nx == num_q) begin
                        state    <= DRAIN;
                        ap_start <= 1'b0;
                    end else begin
                        // Drop start the cycle after the window fills.
                        ap_start <= (occ_nx < OW'(DEPTH));
                    end
                end
                DRAIN: begin
                    if (wd_trip) begin
                        state       <= ERR;
                        timeout_err <= 1'b1;
                        finish      <= 1'b1;
                    end else if (done_nx == num_q) begin
                        state  <= IDLE;
                        finish <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // A done with nothing outstanding is a kernel protocol violation.
            if (ap_done && fifo_empty) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Directed bench for ap_ctrl_sequencer: a serial instance (one outstanding)
// and a windowed instance (two outstanding), both with a 50-cycle watchdog.
module tb_ap_ctrl_sequencer;
    import ap_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // serial instance signals
    logic        s_cfg_start, s_ready, s_done;
    logic [15:0] s_num;
    logic        s_busy, s_finish, s_tmo, s_proto, s_start, s_cont;
    logic [15:0] s_issued, s_dcnt;
    logic [31:0] s_last, s_min, s_max;
    seq_state_e  s_state;

    // windowed instance signals
    logic        p_cfg_start, p_ready, p_done;
    logic [15:0] p_num;
    logic        p_busy, p_finish, p_tmo, p_proto, p_start, p_cont;
    logic [15:0] p_issued, p_dcnt;
    logic [31:0] p_last, p_min, p_max;
    seq_state_e  p_state;

    int total = 0;
    int bad   = 0;
    int s_fin_n = 0;
    int p_fin_n = 0;
    int fin0;
    logic [31:0] exp_q[$];

    ap_ctrl_sequencer #(.CNT_W(16), .LAT_W(32), .TIMEOUT(50), .OUT_LOG2(0)) u_ser (
        .clock(clock), .reset(reset), .cfg_start(s_cfg_start), .cfg_num_txn(s_num),
        .busy(s_busy), .finish(s_finish), .timeout_err(s_tmo), .proto_err(s_proto),
        .ap_start(s_start), .ap_ready(s_ready), .ap_done(s_done), .ap_continue(s_cont),
        .txn_issued(s_issued), .txn_done(s_dcnt), .lat_last(s_last), .lat_min(s_min),
        .lat_max(s_max), .dbg_state(s_state)
    );

    ap_ctrl_sequencer #(.CNT_W(16), .LAT_W(32), .TIMEOUT(50), .OUT_LOG2(1)) u_par (
        .clock(clock), .reset(reset), .cfg_start(p_cfg_start), .cfg_num_txn(p_num),
        .busy(p_busy), .finish(p_finish), .timeout_err(p_tmo), .proto_err(p_proto),
        .ap_start(p_start), .ap_ready(p_ready), .ap_done(p_done), .ap_continue(p_cont),
        .txn_issued(p_issued), .txn_done(p_dcnt), .lat_last(p_last), .lat_min(p_min),
        .lat_max(p_max), .dbg_state(p_state)
    );

    // finish pulse counters
    always @(posedge clock) begin
        if (s_finish === 1'b1) s_fin_n++;
        if (p_finish === 1'b1) p_fin_n++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        s_cfg_start = 0; s_ready = 0; s_done = 0; s_num = '0;
        p_cfg_start = 0; p_ready = 0; p_done = 0; p_num = '0;

        // ---- reset values ----
        tick_n(3);
        chk("rst_s_busy", 32'(s_busy), 0);
        chk("rst_s_start", 32'(s_start), 0);
        chk("rst_s_lat_min", s_min, 32'hFFFF_FFFF);
        chk("rst_s_state", 32'(s_state), 32'(IDLE));
        chk("rst_p_lat_min", p_min, 32'hFFFF_FFFF);
        chk("rst_p_issued", 32'(p_issued), 0);
        reset = 0;
        tick();

        // ---- serial batch N=3, latency 10 each ----
        fin0 = s_fin_n;
        s_num = 16'd3; s_cfg_start = 1; tick(); s_cfg_start = 0;
        chk("s_busy_go", 32'(s_busy), 1);
        for (int k = 1; k <= 3; k++) begin
            chk("s_start_offer", 32'(s_start), 1);
            s_ready = 1; tick(); s_ready = 0;
            chk("s_issued", 32'(s_issued), 32'(k));
            chk("s_start_drop", 32'(s_start), 0);
            tick_n(9);
            s_done = 1; tick(); s_done = 0;
            chk("s_done_cnt", 32'(s_dcnt), 32'(k));
            chk("s_lat_last", s_last, 10);
        end
        chk("s_finish", 32'(s_finish), 1);
        chk("s_busy_end", 32'(s_busy), 0);
        chk("s_lat_min", s_min, 10);
        chk("s_lat_max", s_max, 10);
        tick();
        chk("s_finish_low", 32'(s_finish), 0);
        chk("s_finish_once", 32'(s_fin_n - fin0), 1);

        // ---- zero-length batch, then spurious done in IDLE ----
        s_num = 16'd0; s_cfg_start = 1; tick(); s_cfg_start = 0;
        chk("s_n0_finish", 32'(s_finish), 1);
        chk("s_n0_busy", 32'(s_busy), 0);
        tick();
        chk("s_n0_busy2", 32'(s_busy), 0);
        chk("s_n0_proto_pre", 32'(s_proto), 0);
        s_done = 1; tick(); s_done = 0;
        chk("s_spurious_proto", 32'(s_proto), 1);
        chk("s_spurious_cnt", 32'(s_dcnt), 3);

        // ---- windowed: ready and done in the same cycle ----
        p_num = 16'd2; p_cfg_start = 1; tick(); p_cfg_start = 0;
        p_ready = 1; tick();
        chk("p_sim_start", 32'(p_start), 1);
        p_done = 1; tick(); p_ready = 0; p_done = 0;
        chk("p_sim_issued", 32'(p_issued), 2);
        chk("p_sim_done", 32'(p_dcnt), 1);
        chk("p_sim_proto", 32'(p_proto), 0);
        chk("p_sim_lat", p_last, 1);
        p_done = 1; tick(); p_done = 0;
        chk("p_sim_finish", 32'(p_finish), 1);
        chk("p_sim_done2", 32'(p_dcnt), 2);
        tick();

        // ---- windowed N=4, latencies 5,8,5,8 ----
        exp_q.push_back(5); exp_q.push_back(8); exp_q.push_back(5); exp_q.push_back(8);
        fin0 = p_fin_n;
        p_num = 16'd4; p_cfg_start = 1; tick(); p_cfg_start = 0;
        chk("p_start_go", 32'(p_start), 1);
        p_ready = 1; tick();
        chk("p_start_win1", 32'(p_start), 1);
        chk("p_issued1", 32'(p_issued), 1);
        tick(); p_ready = 0;
        chk("p_start_full", 32'(p_start), 0);
        chk("p_issued2", 32'(p_issued), 2);
        tick_n(3);
        chk("p_start_hold", 32'(p_start), 0);
        p_done = 1; tick(); p_done = 0;
        chk("p_lat_t1", p_last, exp_q.pop_front());
        chk("p_start_reopen", 32'(p_start), 1);
        p_ready = 1; tick(); p_ready = 0;
        chk("p_start_full2", 32'(p_start), 0);
        chk("p_issued3", 32'(p_issued), 3);
        tick_n(2);
        p_done = 1; tick(); p_done = 0;
        chk("p_lat_t2", p_last, exp_q.pop_front());
        chk("p_start_reopen2", 32'(p_start), 1);
        p_ready = 1; tick(); p_ready = 0;
        chk("p_issued4", 32'(p_issued), 4);
        chk("p_start_last", 32'(p_start), 0);
        chk("p_state_drain", 32'(p_state), 32'(DRAIN));
        p_done = 1; tick(); p_done = 0;
        chk("p_lat_t3", p_last, exp_q.pop_front());
        tick_n(6);
        p_done = 1; tick(); p_done = 0;
        chk("p_lat_t4", p_last, exp_q.pop_front());
        chk("p_finish", 32'(p_finish), 1);
        chk("p_busy_end", 32'(p_busy), 0);
        chk("p_done4", 32'(p_dcnt), 4);
        chk("p_lat_min", p_min, 5);
        chk("p_lat_max", p_max, 8);
        tick();
        chk("p_finish_once", 32'(p_fin_n - fin0), 1);

        // ---- watchdog: N=2, kernel never completes ----
        fin0 = p_fin_n;
        p_num = 16'd2; p_cfg_start = 1; tick(); p_cfg_start = 0;
        p_ready = 1; tick_n(2); p_ready = 0;
        chk("wd_issued", 32'(p_issued), 2);
        tick_n(49);
        chk("wd_not_yet", 32'(p_state), 32'(DRAIN));
        chk("wd_tmo_pre", 32'(p_tmo), 0);
        tick();
        chk("wd_state_err", 32'(p_state), 32'(ERR));
        chk("wd_tmo", 32'(p_tmo), 1);
        chk("wd_finish", 32'(p_finish), 1);
        chk("wd_start_low", 32'(p_start), 0);
        tick_n(2);
        chk("wd_finish_once", 32'(p_fin_n - fin0), 1);

        // ---- restart from ERR, then reset mid-DRAIN ----
        p_num = 16'd1; p_cfg_start = 1; tick(); p_cfg_start = 0;
        chk("err_restart", 32'(p_state), 32'(ISSUE));
        chk("err_tmo_clr", 32'(p_tmo), 0);
        p_ready = 1; tick(); p_ready = 0;
        chk("pre_rst_drain", 32'(p_state), 32'(DRAIN));
        fin0 = p_fin_n;
        reset = 1; tick();
        chk("mid_rst_busy", 32'(p_busy), 0);
        chk("mid_rst_issued", 32'(p_issued), 0);
        chk("mid_rst_lat_min", p_min, 32'hFFFF_FFFF);
        chk("mid_rst_finish", 32'(p_finish), 0);
        chk("mid_rst_cont", 32'(p_cont), 0);
        reset = 0;
        tick_n(2);
        chk("mid_rst_no_finish", 32'(p_fin_n - fin0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
